// File: rtl/serializer.sv
// Framed serial transmitter: start(1), TXN_SZ data bits MSB first, even parity, stop(0).
// One-entry holding buffer in front of the shifter allows back-to-back frames.
module serializer #(
   parameter int TXN_SZ     = 8,
   parameter int GAP_CYCLES = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [TXN_SZ-1:0] in_data,
   output logic              sout,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = (TXN_SZ > 1) ? $clog2(TXN_SZ) : 1;
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TXN_SZ - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

   state_t            state, state_next;
   logic [TXN_SZ-1:0] buf_data;
   logic              buf_full;
   logic [TXN_SZ-1:0] shreg;
   logic              par;
   logic [CNT_W-1:0]  bit_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic              load;
   logic              accept;
   logic              sout_next;

   assign accept = in_valid && in_ready;

   // State register plus datapath; everything clears asynchronously, including the buffer word.
   // NOTE: sequential state uses <= only, so every register sees pre-edge values of the others.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         sout     <= 1'b0;
         buf_data <= '0;
         buf_full <= 1'b0;
         shreg    <= '0;
         par      <= 1'b0;
         bit_cnt  <= '0;
         gap_cnt  <= '0;
      end else begin
         state <= state_next;
         sout  <= sout_next;

         if (accept) begin
            buf_data <= in_data;
            buf_full <= 1'b1;
         end else if (load) begin
            buf_full <= 1'b0;
         end

         if (load) begin
            shreg <= buf_data;
            par   <= ^buf_data;
         end else if (state_next == DATA) begin
            shreg <= shreg << 1;
         end

         if (state == START)
            bit_cnt <= CNT_LOAD;
         else if (state == DATA && bit_cnt != '0)
            bit_cnt <= bit_cnt - CNT_W'(1);

         if (state == STOP)
            gap_cnt <= GAP_LOAD;
         else if (state == GAP && gap_cnt != '0)
            gap_cnt <= gap_cnt - GAP_W'(1);
      end
   end

   // NOTE: defaults at the top of each always_comb keep every path assigned, so no latches.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      unique case (state)
         IDLE: begin
            if (buf_full) begin
               state_next = START;
               load       = 1'b1;
            end
         end
         START:  state_next = DATA;
         DATA:   if (bit_cnt == '0) state_next = PARITY;
         PARITY: state_next = STOP;
         STOP: begin
            if (GAP_CYCLES > 0) begin
               state_next = GAP;
            end else if (buf_full) begin
               state_next = START;
               load       = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         GAP: begin
            if (gap_cnt == '0) begin
               if (buf_full) begin
                  state_next = START;
                  load       = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // sout is registered from the next state, so the line value lines up with the state it belongs to.
   always_comb begin
      sout_next = 1'b0;
      unique case (state_next)
         START:   sout_next = 1'b1;
         DATA:    sout_next = shreg[TXN_SZ-1];
         PARITY:  sout_next = par;
         default: sout_next = 1'b0;
      endcase
      done     = (state == STOP);
      busy     = (state != IDLE) || buf_full;
      in_ready = !buf_full && !reset;
   end

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer: two instances (GAP_CYCLES=0 and 2) and a line receiver on the first.
// Expected frames are hand-written 11-bit vectors {start, data[7:0], parity, stop}.
module tb_serializer;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid0 = 1'b0, in_valid2 = 1'b0;
   logic [7:0] in_data0 = '0, in_data2 = '0;
   logic       in_ready0, in_ready2;
   logic       sout0, sout2, busy0, busy2, done0, done2;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clock = ~clock;

   serializer #(.TXN_SZ(8), .GAP_CYCLES(0)) dut0 (
      .clock(clock), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
      .in_data(in_data0), .sout(sout0), .busy(busy0), .done(done0));

   serializer #(.TXN_SZ(8), .GAP_CYCLES(2)) dut2 (
      .clock(clock), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
      .in_data(in_data2), .sout(sout2), .busy(busy2), .done(done2));

   // Receiver on dut0's line: idle low, frame begins on a 1, checks parity and stop.
   int         rx_pos = 0;
   logic [7:0] rx_sh = '0;
   logic       rx_par = 1'b0;
   int         nd_count = 0;
   logic [7:0] rx_q[$];

   always @(negedge clock) begin
      if (reset) begin
         rx_pos = 0;
      end else if (rx_pos == 0) begin
         if (sout0) rx_pos = 1;
      end else if (rx_pos <= 8) begin
         rx_sh  = {rx_sh[6:0], sout0};
         rx_pos = rx_pos + 1;
      end else if (rx_pos == 9) begin
         rx_par = sout0;
         rx_pos = 10;
      end else begin
         if (!sout0 && ((^rx_sh) == rx_par)) begin
            nd_count = nd_count + 1;
            rx_q.push_back(rx_sh);
         end
         rx_pos = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Samples the 11 bit cells of one frame on consecutive falling edges.
   task automatic check_frame(input int sel, input string tag, input logic [10:0] exp);
      for (int i = 10; i >= 0; i--) begin
         @(negedge clock);
         check($sformatf("%s_b%0d", tag, 10 - i), (sel == 0) ? sout0 : sout2, exp[i]);
         check($sformatf("%s_done%0d", tag, 10 - i), (sel == 0) ? done0 : done2, (i == 0));
      end
   endtask

   // Presents one word and returns 1 time unit after the edge that accepted it.
   task automatic push(input int sel, input logic [7:0] d, input string tag);
      logic rdy;
      if (sel == 0) begin in_valid0 = 1'b1; in_data0 = d; end
      else          begin in_valid2 = 1'b1; in_data2 = d; end
      rdy = 1'b0;
      for (int i = 0; i < 50 && !rdy; i++) begin
         @(negedge clock);
         rdy = (sel == 0) ? in_ready0 : in_ready2;
      end
      check({tag, "_ready"}, rdy, 1'b1);
      @(posedge clock); #1;
      if (sel == 0) in_valid0 = 1'b0;
      else          in_valid2 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nd0;
      int ones, busy_hits;

      // Reset state
      #1;
      check("rst_sout", sout0, 1'b0);
      check("rst_busy", busy0, 1'b0);
      check("rst_done", done0, 1'b0);
      check("rst_ready", in_ready0, 1'b0);
      repeat (3) @(posedge clock);
      @(negedge clock); reset = 1'b0;
      #1 check("rel_ready", in_ready0, 1'b1);
      @(posedge clock); #1;

      // V1: 0xA5, start bit one edge after accept, done on the stop cycle only
      push(0, 8'hA5, "v1");
      @(negedge clock);
      check("v1_latency_sout", sout0, 1'b0);
      check("v1_busy", busy0, 1'b1);
      check("v1_ready_full", in_ready0, 1'b0);
      check_frame(0, "v1", 11'b1_10100101_0_0);
      @(negedge clock);
      check("v1_idle_sout", sout0, 1'b0);
      check("v1_idle_busy", busy0, 1'b0);

      // V2: 0x01 has odd weight, parity bit 1; the receiver gets it
      nd0 = nd_count;
      @(posedge clock); #1;
      push(0, 8'h01, "v2");
      @(negedge clock);
      check_frame(0, "v2", 11'b1_00000001_1_0);
      @(negedge clock); #1;
      check("v2_nd", nd_count - nd0, 1);
      check("v2_rx", rx_q[rx_q.size()-1], 8'h01);

      // V3: hold in_valid with 0x3C then 0xFF, frames are back to back
      rx_q.delete();
      @(posedge clock); #1;
      in_valid0 = 1'b1; in_data0 = 8'h3C;
      @(posedge clock); #1;
      in_data0 = 8'hFF;
      @(negedge clock);
      check("v3_ready_3c", in_ready0, 1'b0);
      fork
         check_frame(0, "v3a", 11'b1_00111100_0_0);
         begin
            @(posedge clock);
            @(posedge clock); #1;
            in_valid0 = 1'b0;
            @(negedge clock);
            check("v3_ready_ff", in_ready0, 1'b0);
            check("v3_busy", busy0, 1'b1);
         end
      join
      check_frame(0, "v3b", 11'b1_11111111_0_0);
      @(negedge clock); #1;
      check("v3_idle_sout", sout0, 1'b0);
      check("v3_nrx", rx_q.size(), 2);
      if (rx_q.size() == 2) begin
         check("v3_rx0", rx_q[0], 8'h3C);
         check("v3_rx1", rx_q[1], 8'hFF);
      end

      // V4: GAP_CYCLES=2, 0x55 twice, exactly two low cycles between frames
      @(posedge clock); #1;
      in_valid2 = 1'b1; in_data2 = 8'h55;
      @(posedge clock); #1;
      @(negedge clock);
      check("v4_latency_sout", sout2, 1'b0);
      fork
         check_frame(2, "v4a", 11'b1_01010101_0_0);
         begin
            @(posedge clock);
            @(posedge clock); #1;
            in_valid2 = 1'b0;
            @(negedge clock);
            check("v4_ready_full", in_ready2, 1'b0);
         end
      join
      for (int g = 0; g < 2; g++) begin
         @(negedge clock);
         check($sformatf("v4_gap%0d_sout", g), sout2, 1'b0);
         check($sformatf("v4_gap%0d_busy", g), busy2, 1'b1);
      end
      check_frame(2, "v4b", 11'b1_01010101_0_0);
      repeat (2) @(negedge clock);
      check("v4_tailgap_busy", busy2, 1'b1);
      @(negedge clock);
      check("v4_idle_busy", busy2, 1'b0);

      // V5: reset on the 4th data bit of 0xC3 while 0x11 is buffered
      nd0 = nd_count;
      @(posedge clock); #1;
      in_valid0 = 1'b1; in_data0 = 8'hC3;
      @(posedge clock); #1;
      in_data0 = 8'h11;
      @(posedge clock);
      @(posedge clock); #1;
      in_valid0 = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("v5_bit4", sout0, 1'b0);
      check("v5_ready_full", in_ready0, 1'b0);
      reset = 1'b1; in_valid0 = 1'b1; in_data0 = 8'hAA;
      #1;
      check("v5_rst_sout", sout0, 1'b0);
      check("v5_rst_busy", busy0, 1'b0);
      check("v5_rst_done", done0, 1'b0);
      check("v5_rst_ready", in_ready0, 1'b0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      in_valid0 = 1'b0; reset = 1'b0;
      #1 check("v5_rel_ready", in_ready0, 1'b1);
      ones = 0; busy_hits = 0;
      repeat (15) begin
         @(negedge clock);
         ones += int'(sout0);
         busy_hits += int'(busy0);
      end
      check("v5_no_tx", ones, 0);
      check("v5_no_busy", busy_hits, 0);
      check("v5_nd", nd_count - nd0, 0);
      @(posedge clock); #1;
      push(0, 8'h7E, "v5");
      @(negedge clock);
      check_frame(0, "v5", 11'b1_01111110_0_0);
      @(negedge clock); #1;
      check("v5_rx", rx_q[rx_q.size()-1], 8'h7E);

      // V6: in_data churns every cycle after 0x81 is accepted
      @(posedge clock); #1;
      push(0, 8'h81, "v6");
      fork
         begin
            @(negedge clock);
            check_frame(0, "v6", 11'b1_10000001_0_0);
         end
         for (int c = 0; c < 13; c++) begin
            in_data0 = 8'($urandom);
            @(posedge clock); #1;
         end
      join
      @(negedge clock);
      check("v6_idle_busy", busy0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 The module SHALL have parameter TXN_SZ, default 8, giving the payload bits per transaction.
REQ-002 The module SHALL have parameter GAP_CYCLES, default 0, giving the number of extra idle (low) cycles inserted after each stop bit.
REQ-003 The module SHALL have port clock, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: in_data holds a word to send.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the holding buffer is empty and can accept a word.
REQ-007 The module SHALL have port in_data, input, TXN_SZ bits: the payload word.
REQ-008 The module SHALL have port sout, output, 1 bit: the registered serial line.
REQ-009 The module SHALL have port busy, output, 1 bit: a frame or gap is in progress, or the buffer is occupied.
REQ-010 The module SHALL have port done, output, 1 bit: a one-cycle pulse during the stop-bit cycle of each frame.

Function
REQ-011 The module SHALL emit each frame on sout as 1 start bit (1), then TXN_SZ data bits MSB first, then 1 parity bit, then 1 stop bit (0), with each bit held for exactly one clock cycle.
REQ-012 The parity bit SHALL equal the XOR of all TXN_SZ data bits, so that data XOR parity = 0 (even parity).
REQ-013 sout SHALL be 0 whenever no frame is in progress (idle line low).
REQ-014 A word SHALL be accepted on any rising edge where in_valid=1 and in_ready=1, and it SHALL be stored in a one-entry holding buffer.
REQ-015 in_ready SHALL be the negation of the buffer-full flag; the module SHALL NOT buffer more than one pending word.
REQ-016 The state machine SHALL have the states IDLE, START, DATA, PARITY, STOP and GAP.
REQ-017 In IDLE, when the buffer is full, the next edge SHALL move the word into the shift register, clear the buffer, enter START and drive sout=1.
REQ-018 START SHALL go to DATA after one cycle, with sout driven to the data MSB.
REQ-019 DATA SHALL use a bit counter, of width ceil(log2(TXN_SZ)), loaded with TXN_SZ-1 and decremented each cycle; when the counter is 0, the next state SHALL be PARITY.
REQ-020 PARITY SHALL go to STOP after one cycle, with sout driven to 0.
REQ-021 STOP SHALL lead to one of three next states, and done SHALL be 1 for exactly this cycle:
 - GAP, if GAP_CYCLES>0;
 - START with the buffered word, if GAP_CYCLES=0 and the buffer is full (back-to-back frames, no idle bit);
 - IDLE otherwise.
REQ-022 GAP SHALL hold sout=0 for exactly GAP_CYCLES cycles, then behave as REQ-017 (go to START if the buffer is full, otherwise IDLE).
REQ-023 The latency SHALL be as follows: a word accepted at edge k while in IDLE with an empty buffer SHALL put the start bit on sout from edge k+1.
REQ-024 The frame period SHALL be exactly TXN_SZ+3+GAP_CYCLES cycles under sustained input.
REQ-025 A new word accepted during the STOP or GAP cycle SHALL be sent without an extra idle cycle.
REQ-026 busy SHALL equal (state != IDLE) OR buffer-full.
REQ-027 in_data SHALL be sampled only on the accept edge; later changes to in_data SHALL NOT affect a queued or in-flight frame.

Reset
REQ-028 Asserting reset SHALL immediately, at any point including mid-frame, force the following, with no partial frame completed:
 - state to IDLE;
 - sout, done and busy to 0;
 - the buffer to empty;
 - the counter and shift register to 0.
REQ-029 While reset is asserted, in_ready SHALL be 0 and in_valid SHALL be ignored.
REQ-030 in_ready SHALL be 1 from the first cycle after reset deasserts.

Verification
REQ-031 Bench scenarios (TXN_SZ=8, GAP_CYCLES=0 unless stated):
 - V1: send 0xA5 → sout = 1,1,0,1,0,0,1,0,1,0,0 (start, data, parity 0, stop), then 0; done is pulsed once on the stop cycle.
 - V2: send 0x01 → parity bit 1; the frame lasts 11 cycles; a copy of the team's deserializer on the same line reports nd=1 with data=0x01.
 - V3: hold in_valid with 0x3C then 0xFF → the 0xFF start bit directly follows the 0x3C stop bit; in_ready deasserts while the buffer holds 0xFF; the deserializer receives both words.
 - V4: GAP_CYCLES=2, send 0x55 twice back-to-back → exactly 2 low cycles between the stop bit and the next start bit; the period is 13 cycles.
 - V5: assert reset on the 4th data bit of 0xC3 while 0x11 is buffered → sout=0 and busy=0 immediately; neither word is transmitted after release; the next accepted 0x7E frames correctly.
 - V6: change in_data on every cycle after the accept of 0x81 → the transmitted bits match 0x81 with parity 0.
